// File: rtl/sfi5_diag_sequencer.sv
// sfi5_diag_sequencer
//   Runs one self-test of an SFI-5 16-bit link through its diagnostic controls.
//   The sequence is: apply loopback, wait for TX/RX init and frame lock, let the
//   link settle, clear the counters and confirm they stay clean, inject one frame
//   error and see it counted, then inject one data error and see a mismatch counted.
//   The run ends in DONE with a pass flag and a failure code.
// Ports
//   i_CLK, i_RST             clock; synchronous active-high reset
//   i_START                  start pulse, accepted only in IDLE or DONE
//   iv_LOOPBACK_MODE         loopback value captured on the accepted start
//   i_TX_INIT_DONE,
//   i_RX_INIT_DONE,
//   i_RXLOF, i_RXOOA         link status from the interface
//   iv_FRAME_ERRORS,
//   iv_DATA_MISMATCHES       interface error counters (unsigned)
//   o_LOOPBACK               loopback control to the interface
//   o_CLEAR_*, o_INSERT_*    single-cycle diagnostic pulses
//   o_BUSY, o_DONE, o_PASS   run status
//   ov_FAIL_CODE             0 pass, 1 init timeout, 2 lock lost while settling,
//                            3 counters dirty after clear, 4 frame error not seen,
//                            5 mismatch not seen, 6 lock lost while checking
module sfi5_diag_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned TIMEOUT       = 65535,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_START,
  input  logic [2:0]       iv_LOOPBACK_MODE,
  input  logic             i_TX_INIT_DONE,
  input  logic             i_RX_INIT_DONE,
  input  logic             i_RXLOF,
  input  logic             i_RXOOA,
  input  logic [CNT_W-1:0] iv_FRAME_ERRORS,
  input  logic [CNT_W-1:0] iv_DATA_MISMATCHES,
  output logic [2:0]       o_LOOPBACK,
  output logic             o_CLEAR_FRAME_ERRORS,
  output logic             o_CLEAR_MISMATCHES,
  output logic             o_INSERT_FRAME_ERROR,
  output logic             o_INSERT_DATA_ERROR,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_PASS,
  output logic [2:0]       ov_FAIL_CODE
);

  localparam int unsigned MAX_WAIT = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned TW       = $clog2(MAX_WAIT + 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_INIT, SETTLE, CLEAR, CHK_CLEAN,
    INJ_FRAME, CHK_FRAME, INJ_DATA, CHK_DATA, DONE
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic [2:0]    lb_n;
  logic          pass_n;
  logic [2:0]    code_n;

  // Within each state the checks are ordered fail, then advance, then timeout,
  // so a later assignment never overrides a higher-priority outcome.
  always_comb begin
    state_n = state;
    lb_n    = o_LOOPBACK;
    pass_n  = o_PASS;
    code_n  = ov_FAIL_CODE;
    unique case (state)
      IDLE, DONE: begin
        if (i_START) begin
          lb_n    = iv_LOOPBACK_MODE;
          pass_n  = 1'b0;
          code_n  = 3'd0;
          state_n = WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        if (i_TX_INIT_DONE && i_RX_INIT_DONE && !i_RXLOF && !i_RXOOA) begin
          state_n = SETTLE;
        end else if (timer == TO_LAST) begin
          code_n  = 3'd1;
          state_n = DONE;
        end
      end
      SETTLE: begin
        if (i_RXLOF) begin
          code_n  = 3'd2;
          state_n = DONE;
        end else if (timer == SETTLE_LAST) begin
          state_n = CLEAR;
        end
      end
      CLEAR: state_n = CHK_CLEAN;
      CHK_CLEAN: begin
        if (i_RXLOF) begin
          code_n  = 3'd6;
          state_n = DONE;
        end else if (timer == SETTLE_LAST) begin
          if (iv_FRAME_ERRORS == '0 && iv_DATA_MISMATCHES == '0) begin
            state_n = INJ_FRAME;
          end else begin
            code_n  = 3'd3;
            state_n = DONE;
          end
        end
      end
      INJ_FRAME: state_n = CHK_FRAME;
      CHK_FRAME: begin
        if (iv_FRAME_ERRORS != '0) begin
          state_n = INJ_DATA;
        end else if (timer == TO_LAST) begin
          code_n  = 3'd4;
          state_n = DONE;
        end
      end
      INJ_DATA: state_n = CHK_DATA;
      CHK_DATA: begin
        if (i_RXLOF) begin
          code_n  = 3'd6;
          state_n = DONE;
        end else if (iv_DATA_MISMATCHES != '0) begin
          pass_n  = 1'b1;
          code_n  = 3'd0;
          state_n = DONE;
        end else if (timer == TO_LAST) begin
          code_n  = 3'd5;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == DONE || state_n == IDLE) begin
      lb_n = 3'd0;
    end
  end

  // Outputs are registered from the next state, so each pulse is high exactly
  // for the single cycle spent in its one-cycle state.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state                <= IDLE;
      timer                <= '0;
      o_LOOPBACK           <= '0;
      o_CLEAR_FRAME_ERRORS <= 1'b0;
      o_CLEAR_MISMATCHES   <= 1'b0;
      o_INSERT_FRAME_ERROR <= 1'b0;
      o_INSERT_DATA_ERROR  <= 1'b0;
      o_BUSY               <= 1'b0;
      o_DONE               <= 1'b0;
      o_PASS               <= 1'b0;
      ov_FAIL_CODE         <= '0;
    end else begin
      state                <= state_n;
      timer                <= (state_n != state) ? '0 : timer + 1'b1;
      o_LOOPBACK           <= lb_n;
      o_CLEAR_FRAME_ERRORS <= (state_n == CLEAR);
      o_CLEAR_MISMATCHES   <= (state_n == CLEAR);
      o_INSERT_FRAME_ERROR <= (state_n == INJ_FRAME);
      o_INSERT_DATA_ERROR  <= (state_n == INJ_DATA);
      o_BUSY               <= !(state_n == IDLE || state_n == DONE);
      o_DONE               <= (state_n == DONE);
      o_PASS               <= pass_n;
      ov_FAIL_CODE         <= code_n;
    end
  end

endmodule

// File: tb/tb_sfi5_diag_sequencer.sv
// Bench for sfi5_diag_sequencer with a small reactive link model:
// init done 5 cycles into a run, counters react 3 cycles after each pulse.
module tb_sfi5_diag_sequencer;
  localparam int unsigned SC = 8;
  localparam int unsigned TO = 32;

  logic        i_CLK = 1'b0;
  logic        i_RST, i_START;
  logic [2:0]  iv_LOOPBACK_MODE;
  logic        i_TX_INIT_DONE, i_RX_INIT_DONE, i_RXLOF, i_RXOOA;
  logic [15:0] iv_FRAME_ERRORS, iv_DATA_MISMATCHES;
  logic [2:0]  o_LOOPBACK;
  logic        o_CLEAR_FRAME_ERRORS, o_CLEAR_MISMATCHES;
  logic        o_INSERT_FRAME_ERROR, o_INSERT_DATA_ERROR;
  logic        o_BUSY, o_DONE, o_PASS;
  logic [2:0]  ov_FAIL_CODE;

  sfi5_diag_sequencer #(.SETTLE_CYCLES(SC), .TIMEOUT(TO), .CNT_W(16)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_START(i_START), .iv_LOOPBACK_MODE(iv_LOOPBACK_MODE),
    .i_TX_INIT_DONE(i_TX_INIT_DONE), .i_RX_INIT_DONE(i_RX_INIT_DONE),
    .i_RXLOF(i_RXLOF), .i_RXOOA(i_RXOOA),
    .iv_FRAME_ERRORS(iv_FRAME_ERRORS), .iv_DATA_MISMATCHES(iv_DATA_MISMATCHES),
    .o_LOOPBACK(o_LOOPBACK),
    .o_CLEAR_FRAME_ERRORS(o_CLEAR_FRAME_ERRORS), .o_CLEAR_MISMATCHES(o_CLEAR_MISMATCHES),
    .o_INSERT_FRAME_ERROR(o_INSERT_FRAME_ERROR), .o_INSERT_DATA_ERROR(o_INSERT_DATA_ERROR),
    .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_PASS(o_PASS), .ov_FAIL_CODE(ov_FAIL_CODE)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic       pass;
    logic [2:0] code;
    int         clr;
    int         ins_f;
    int         ins_d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // link model configuration
  bit       rx_stuck, frame_stuck, ign_f, ign_d, start_mid;
  int       lof_mode;
  logic [2:0] run_mode;
  // link model state and run observations
  int       busy_age, busy_cyc, insf_cyc, done_cyc;
  logic [2:0] clr_d, insf_d, insd_d;
  int       n_clr_f, n_clr_m, n_insf, n_insd, lb_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, observe outputs #1 after the edge, update the link model.
  task automatic step();
    @(posedge i_CLK);
    #1;
    cyc++;
    clr_d  = {clr_d[1:0],  o_CLEAR_FRAME_ERRORS};
    insf_d = {insf_d[1:0], o_INSERT_FRAME_ERROR};
    insd_d = {insd_d[1:0], o_INSERT_DATA_ERROR};
    n_clr_f += int'(o_CLEAR_FRAME_ERRORS);
    n_clr_m += int'(o_CLEAR_MISMATCHES);
    n_insf  += int'(o_INSERT_FRAME_ERROR);
    n_insd  += int'(o_INSERT_DATA_ERROR);
    if (o_INSERT_FRAME_ERROR) insf_cyc = cyc;
    if (o_BUSY) begin
      busy_age++;
      if (busy_age == 1) busy_cyc = cyc;
      if (o_LOOPBACK !== run_mode) lb_bad++;
    end else begin
      busy_age = 0;
    end
    i_TX_INIT_DONE = (busy_age >= 5);
    i_RX_INIT_DONE = (busy_age >= 5) && !rx_stuck;
    i_RXLOF = 1'b0;
    if (lof_mode == 1 && busy_age == 8) i_RXLOF = 1'b1;
    if (clr_d[2]) begin
      iv_FRAME_ERRORS    = frame_stuck ? 16'd5 : 16'd0;
      iv_DATA_MISMATCHES = 16'd0;
    end
    if (insf_d[2] && !ign_f) iv_FRAME_ERRORS = iv_FRAME_ERRORS + 16'd1;
    if (lof_mode == 2 && insd_d[1]) begin
      i_RXLOF            = 1'b1;
      iv_DATA_MISMATCHES = 16'd1;
    end
    if (insd_d[2] && !ign_d && lof_mode != 2) iv_DATA_MISMATCHES = iv_DATA_MISMATCHES + 16'd1;
  endtask

  task automatic set_cfg(input bit rs, input bit fs, input bit igf, input bit igd, input int lm);
    rx_stuck = rs; frame_stuck = fs; ign_f = igf; ign_d = igd; lof_mode = lm; start_mid = 1'b0;
  endtask

  task automatic begin_run(input logic [2:0] mode);
    n_clr_f = 0; n_clr_m = 0; n_insf = 0; n_insd = 0; lb_bad = 0;
    clr_d = '0; insf_d = '0; insd_d = '0;
    run_mode = mode;
    iv_FRAME_ERRORS = 16'd3;
    iv_DATA_MISMATCHES = 16'd9;
    i_START = 1'b1;
    iv_LOOPBACK_MODE = mode;
    step();
    i_START = 1'b0;
    iv_LOOPBACK_MODE = ~mode;
  endtask

  task automatic run(input string nm, input logic [2:0] mode, input logic xpass, input logic [2:0] xcode,
                     input int xclr, input int xinsf, input int xinsd);
    exp_t e;
    int   k;
    sb.push_back('{pass: xpass, code: xcode, clr: xclr, ins_f: xinsf, ins_d: xinsd});
    begin_run(mode);
    check({nm, "_busy_after_start"}, {31'd0, o_BUSY}, 32'd1);
    check({nm, "_done_low_after_start"}, {31'd0, o_DONE}, 32'd0);
    k = 0;
    while (!o_DONE && k < 2000) begin
      if (start_mid && busy_age == 2) begin
        i_START = 1'b1;
        iv_LOOPBACK_MODE = 3'b110;
      end
      step();
      i_START = 1'b0;
      k++;
    end
    done_cyc = cyc;
    check({nm, "_done_reached"}, {31'd0, o_DONE}, 32'd1);
    e = sb.pop_front();
    check({nm, "_pass"}, {31'd0, o_PASS}, {31'd0, e.pass});
    check({nm, "_code"}, {29'd0, ov_FAIL_CODE}, {29'd0, e.code});
    check({nm, "_busy_in_done"}, {31'd0, o_BUSY}, 32'd0);
    check({nm, "_loopback_in_done"}, {29'd0, o_LOOPBACK}, 32'd0);
    check({nm, "_loopback_while_busy_bad"}, 32'(lb_bad), 32'd0);
    check({nm, "_clear_frame_pulses"}, 32'(n_clr_f), 32'(e.clr));
    check({nm, "_clear_mism_pulses"}, 32'(n_clr_m), 32'(e.clr));
    check({nm, "_insert_frame_pulses"}, 32'(n_insf), 32'(e.ins_f));
    check({nm, "_insert_data_pulses"}, 32'(n_insd), 32'(e.ins_d));
    // DONE must hold its result
    step();
    check({nm, "_done_hold"}, {31'd0, o_DONE}, 32'd1);
    check({nm, "_code_hold"}, {29'd0, ov_FAIL_CODE}, {29'd0, e.code});
  endtask

  initial begin
    int k;
    i_RST = 1'b1; i_START = 1'b0; iv_LOOPBACK_MODE = '0;
    i_TX_INIT_DONE = 1'b0; i_RX_INIT_DONE = 1'b0; i_RXLOF = 1'b0; i_RXOOA = 1'b0;
    iv_FRAME_ERRORS = '0; iv_DATA_MISMATCHES = '0;
    set_cfg(0, 0, 0, 0, 0);
    run_mode = '0;
    step();
    step();
    i_RST = 1'b0;
    check("reset_busy", {31'd0, o_BUSY}, 32'd0);
    check("reset_done", {31'd0, o_DONE}, 32'd0);
    check("reset_pass", {31'd0, o_PASS}, 32'd0);
    check("reset_code", {29'd0, ov_FAIL_CODE}, 32'd0);
    check("reset_loopback", {29'd0, o_LOOPBACK}, 32'd0);
    step();

    // ideal link
    set_cfg(0, 0, 0, 0, 0);
    run("ideal", 3'b001, 1'b1, 3'd0, 1, 1, 1);

    // RX init never completes
    set_cfg(1, 0, 0, 0, 0);
    run("init_to", 3'b010, 1'b0, 3'd1, 0, 0, 0);
    check("init_to_latency", 32'(done_cyc - busy_cyc), 32'd32);

    // frame counter stuck nonzero after clear
    set_cfg(0, 1, 0, 0, 0);
    run("dirty", 3'b011, 1'b0, 3'd3, 1, 0, 0);

    // frame insert ignored
    set_cfg(0, 0, 1, 0, 0);
    run("frame_missing", 3'b100, 1'b0, 3'd4, 1, 1, 0);
    check("frame_missing_latency", 32'(done_cyc - insf_cyc), 32'd33);

    // data insert ignored
    set_cfg(0, 0, 0, 1, 0);
    run("data_missing", 3'b101, 1'b0, 3'd5, 1, 1, 1);

    // RXLOF glitch while settling
    set_cfg(0, 0, 0, 0, 1);
    run("lof_settle", 3'b001, 1'b0, 3'd2, 0, 0, 0);

    // RXLOF together with a mismatch in CHK_DATA: failure wins
    set_cfg(0, 0, 0, 0, 2);
    run("lof_chk_data", 3'b111, 1'b0, 3'd6, 1, 1, 1);

    // start while busy is ignored; this run itself starts from DONE
    set_cfg(0, 0, 0, 0, 0);
    start_mid = 1'b1;
    run("start_busy", 3'b011, 1'b1, 3'd0, 1, 1, 1);
    start_mid = 1'b0;

    // reset while in CHK_FRAME
    set_cfg(0, 0, 1, 0, 0);
    begin_run(3'b010);
    k = 0;
    while (!o_INSERT_FRAME_ERROR && k < 500) begin
      step();
      k++;
    end
    check("rst_reached_inj_frame", {31'd0, o_INSERT_FRAME_ERROR}, 32'd1);
    step();
    step();
    check("rst_still_busy", {31'd0, o_BUSY}, 32'd1);
    i_RST = 1'b1;
    step();
    i_RST = 1'b0;
    check("rst_busy", {31'd0, o_BUSY}, 32'd0);
    check("rst_done", {31'd0, o_DONE}, 32'd0);
    check("rst_pass", {31'd0, o_PASS}, 32'd0);
    check("rst_code", {29'd0, ov_FAIL_CODE}, 32'd0);
    check("rst_loopback", {29'd0, o_LOOPBACK}, 32'd0);
    check("rst_pulses", {28'd0, o_CLEAR_FRAME_ERRORS, o_CLEAR_MISMATCHES,
                         o_INSERT_FRAME_ERROR, o_INSERT_DATA_ERROR}, 32'd0);
    step();
    check("rst_idle_stays", {30'd0, o_BUSY, o_DONE}, 32'd0);

    // fresh run from IDLE after reset
    set_cfg(0, 0, 0, 0, 0);
    run("after_reset", 3'b110, 1'b1, 3'd0, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1, "time limit");
  end
endmodule
